// File: rtl/xbar_params_pkg.sv
// Benes geometry shared by the crossbar and the cabbage control generators,
// so both ends of the perm -> ctrl interface agree on bit placement and wiring.
package xbar_params;

    function automatic int tag_width(input int size);
        return $clog2(size);
    endfunction

    function automatic int num_stages(input int size);
        return 2 * tag_width(size) - 1;
    endfunction

    function automatic int bit_width(input int size);
        return num_stages(size) * (size / 2);
    endfunction

    function automatic int ctrl_bit_index(input int size, input int stage, input int sw);
        return stage * (size / 2) + sw;
    endfunction

    // Unshuffle on the input half, inverse shuffle on the output half; the last column feeds lanes directly.
    function automatic int shuffle_dst(input int size, input int stage, input int pos);
        int tw;
        int st;
        int m;
        int base;
        int r;
        tw = tag_width(size);
        st = num_stages(size);
        if (stage >= st - 1) return pos;
        m = (stage < tw - 1) ? (size >> stage) : (size >> (st - 2 - stage));
        base = pos - (pos % m);
        r = pos % m;
        if (stage < tw - 1) return base + (((r % 2) == 0) ? r / 2 : r / 2 + m / 2);
        return base + ((r < m / 2) ? 2 * r : 2 * (r - m / 2) + 1);
    endfunction

endpackage

// File: rtl/benes_xbar_pipelined_stage.sv
// One column of SIZE/2 2x2 switches followed by the fixed wiring to the next column.
module benes_stage
    import xbar_params::*;
#(
    parameter int SIZE   = 32,
    parameter int DWIDTH = 32,
    parameter int STAGE  = 0
)(
    input  logic [SIZE-1:0][DWIDTH-1:0] din,
    input  logic [SIZE/2-1:0]           sw,
    output logic [SIZE-1:0][DWIDTH-1:0] dout
);

    logic [SIZE-1:0][DWIDTH-1:0] swd;

    for (genvar k = 0; k < SIZE / 2; k++) begin : g_sw
        assign swd[2*k]   = sw[k] ? din[2*k+1] : din[2*k];
        assign swd[2*k+1] = sw[k] ? din[2*k]   : din[2*k+1];
    end

    for (genvar p = 0; p < SIZE; p++) begin : g_wire
        assign dout[shuffle_dst(SIZE, STAGE, p)] = swd[p];
    end

endmodule

// File: rtl/benes_xbar_pipelined.sv
// Pipelined Benes data crossbar: every beat carries its own switch settings and
// travels with the still-unapplied ctrl bits through elastic register slots.
module benes_xbar_pipelined
    import xbar_params::*;
#(
    parameter  int SIZE       = 32,
    parameter  int DWIDTH     = 32,
    parameter  int REG_STRIDE = 2,
    localparam int TAGWIDTH   = tag_width(SIZE),
    localparam int STAGES     = 2 * TAGWIDTH - 1,
    localparam int BITWIDTH   = STAGES * (SIZE / 2),
    localparam int LAT        = (STAGES + REG_STRIDE - 1) / REG_STRIDE
)(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_ctrl,
    input  logic [DWIDTH-1:0]   in_data [SIZE-1:0],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   out_data [SIZE-1:0]
);

    localparam int HALF   = SIZE / 2;
    localparam int CSLOTS = (LAT > 1) ? LAT - 1 : 1;

    typedef logic [SIZE-1:0][DWIDTH-1:0] lanes_t;

    lanes_t              in_lanes;
    lanes_t              stage_in   [STAGES];
    lanes_t              stage_out  [STAGES];
    lanes_t              seg_in     [LAT];
    lanes_t              seg_out    [LAT];
    logic [BITWIDTH-1:0] seg_ctrl   [LAT];
    logic [LAT-1:0]      seg_valid;
    logic [LAT-1:0]      slot_valid;
    logic [LAT-1:0]      load;
    lanes_t              slot_data  [LAT];
    logic [BITWIDTH-1:0] slot_ctrl  [CSLOTS];

    // Bits for stages already applied are zeroed so their flops reduce to constants.
    function automatic logic [BITWIDTH-1:0] keep_mask(input int j);
        return {BITWIDTH{1'b1}} << ((j + 1) * REG_STRIDE * HALF);
    endfunction

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            in_lanes[i] = in_data[i];
            out_data[i] = slot_data[LAT-1][i];
        end
    end

    for (genvar j = 0; j < LAT; j++) begin : g_seg
        localparam int LAST = (((j + 1) * REG_STRIDE < STAGES) ? (j + 1) * REG_STRIDE : STAGES) - 1;
        if (j == 0) begin : g_head
            assign seg_in[j]    = in_lanes;
            assign seg_ctrl[j]  = in_ctrl;
            assign seg_valid[j] = in_valid;
        end else begin : g_body
            assign seg_in[j]    = slot_data[j-1];
            assign seg_ctrl[j]  = slot_ctrl[j-1];
            assign seg_valid[j] = slot_valid[j-1];
        end
        assign seg_out[j] = stage_out[LAST];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int G = s / REG_STRIDE;
        if (s % REG_STRIDE == 0) begin : g_first
            assign stage_in[s] = seg_in[G];
        end else begin : g_chain
            assign stage_in[s] = stage_out[s-1];
        end
        benes_stage #(
            .SIZE   (SIZE),
            .DWIDTH (DWIDTH),
            .STAGE  (s)
        ) u_stage (
            .din  (stage_in[s]),
            .sw   (seg_ctrl[G][s*HALF +: HALF]),
            .dout (stage_out[s])
        );
    end

    // Ready ripples back from out_ready through every slot in one cycle.
    always_comb begin
        load = '0;
        load[LAT-1] = !slot_valid[LAT-1] || out_ready;
        for (int j = LAT - 2; j >= 0; j--) begin
            load[j] = !slot_valid[j] || load[j+1];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            slot_valid <= '0;
            for (int j = 0; j < LAT; j++) slot_data[j] <= '0;
            for (int j = 0; j < CSLOTS; j++) slot_ctrl[j] <= '0;
        end else begin
            for (int j = 0; j < LAT; j++) begin
                if (load[j]) begin
                    slot_valid[j] <= seg_valid[j];
                    if (seg_valid[j]) slot_data[j] <= seg_out[j];
                end
            end
            for (int j = 0; j < LAT - 1; j++) begin
                if (load[j] && seg_valid[j]) slot_ctrl[j] <= seg_ctrl[j] & keep_mask(j);
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = slot_valid[LAT-1];

endmodule

// File: tb/tb_benes_xbar_pipelined.sv
// Bench for benes_xbar_pipelined: a permutation-level model (out[perm[i]] = in[i])
// with its own Benes router, checked against the DUT on every output cycle.
module tb_benes_xbar_pipelined;

    localparam int SIZE       = 32;
    localparam int DWIDTH     = 32;
    localparam int REG_STRIDE = 2;
    localparam int TAGWIDTH   = 5;
    localparam int STAGES     = 9;
    localparam int HALF       = 16;
    localparam int BITWIDTH   = 144;
    localparam int LAT        = 5;

    typedef logic [SIZE-1:0][DWIDTH-1:0] lanes_t;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] in_ctrl;
    logic [DWIDTH-1:0]   in_data [SIZE-1:0];
    logic                out_valid;
    logic                out_ready;
    logic [DWIDTH-1:0]   out_data [SIZE-1:0];

    int     checks = 0;
    int     errors = 0;
    int     out_count = 0;
    bit     stall_seen = 1'b0;
    lanes_t exp_q [$];
    lanes_t out_lanes;
    lanes_t data_v;
    int     perm_v [SIZE];
    int     gold_perm [SIZE];
    logic [BITWIDTH-1:0] ctrl_v;
    logic [BITWIDTH-1:0] gold_ctrl;
    int     gold_list [SIZE] = '{14, 22, 25, 11, 21, 6, 15, 5, 30, 23, 18, 28, 19, 17, 31, 12,
                                 26, 16, 13, 3, 9, 8, 0, 1, 10, 20, 7, 4, 29, 2, 24, 27};

    benes_xbar_pipelined #(
        .SIZE       (SIZE),
        .DWIDTH     (DWIDTH),
        .REG_STRIDE (REG_STRIDE)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < SIZE; i++) out_lanes[i] = out_data[i];
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkLanes(input string name, input lanes_t actual, input lanes_t expected);
        int bad;
        bad = -1;
        checks++;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (actual[i] !== expected[i]) bad = i;
        end
        if (bad >= 0) begin
            errors++;
            $display("[TB] FAIL %s: lane %0d got %0d expected %0d at %0t",
                     name, bad, actual[bad], expected[bad], $time);
        end
    endtask

    // Looping-algorithm router: derives switch settings from perm_v into ctrl_v.
    task automatic computeCtrl();
        int cur [SIZE];
        int nxt [SIZE];
        int lp [SIZE];
        int linv [SIZE];
        int side [SIZE];
        int m;
        int h;
        int base;
        int i;
        int t;
        ctrl_v = '0;
        cur = perm_v;
        nxt = perm_v;
        for (int d = 0; d < TAGWIDTH - 1; d++) begin
            m = SIZE >> d;
            h = m / 2;
            for (int b = 0; b < SIZE / m; b++) begin
                base = b * m;
                for (int x = 0; x < m; x++) begin
                    lp[x] = cur[base + x] - base;
                    side[x] = -1;
                end
                for (int x = 0; x < m; x++) linv[lp[x]] = x;
                for (int k = 0; k < h; k++) begin
                    i = 2 * k;
                    while (side[i] < 0) begin
                        side[i] = 0;
                        side[i ^ 1] = 1;
                        i = linv[lp[i ^ 1] ^ 1];
                    end
                end
                for (int k = 0; k < h; k++) begin
                    t = (side[2*k] == 0) ? 2 * k : 2 * k + 1;
                    ctrl_v[d * HALF + base / 2 + k] = (side[2*k] != 0);
                    ctrl_v[(STAGES - 1 - d) * HALF + base / 2 + k] = (side[linv[2*k]] != 0);
                    nxt[base + k] = base + lp[t] / 2;
                    nxt[base + h + k] = base + h + lp[t ^ 1] / 2;
                end
            end
            cur = nxt;
        end
        for (int b = 0; b < HALF; b++) ctrl_v[(TAGWIDTH - 1) * HALF + b] = (cur[2*b] != 2 * b);
    endtask

    task automatic setIdentity();
        for (int i = 0; i < SIZE; i++) perm_v[i] = i;
        ctrl_v = '0;
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        in_ctrl = 'x;
        for (int i = 0; i < SIZE; i++) in_data[i] = 'x;
    endtask

    // Presents one beat, waits for acceptance and records what the output must be.
    task automatic applyStimulus();
        lanes_t e;
        int     waited;
        bit     accepted;
        e = '0;
        in_ctrl = ctrl_v;
        for (int i = 0; i < SIZE; i++) in_data[i] = data_v[i];
        for (int i = 0; i < SIZE; i++) e[perm_v[i]] = data_v[i];
        in_valid = 1'b1;
        waited = 0;
        accepted = 1'b0;
        while (!accepted && waited <= 100) begin
            @(posedge clk);
            if (in_ready) accepted = 1'b1;
            else begin
                stall_seen = 1'b1;
                waited++;
            end
        end
        if (accepted) exp_q.push_back(e);
        else checkOutput("accept_timeout", waited, 0);
        #1;
    endtask

    task automatic measureLatency(input string name);
        int c;
        bit seen;
        seen = 1'b0;
        for (c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            checkOutput({name, "_in_ready"}, in_ready, 1);
            if (out_valid) seen = 1'b1;
        end
        checkOutput(name, seen ? c - 1 : -1, LAT - 1);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, exp_q.size(), 0);
    endtask

    // Scoreboard: every visible beat must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (n_rst && out_valid) begin
            checkOutput("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                checkLanes("stream", out_lanes, exp_q[0]);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    out_count++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt0;
        n_rst = 1'b0;
        out_ready = 1'b1;
        idleInputs();
        for (int i = 0; i < SIZE; i++) gold_perm[i] = gold_list[SIZE - 1 - i];
        perm_v = gold_perm;
        computeCtrl();
        gold_ctrl = ctrl_v;

        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_data_zero", out_lanes == '0, 1);
        @(negedge clk);
        n_rst = 1'b1;

        $display("[TB] identity beat");
        @(posedge clk);
        #1;
        setIdentity();
        for (int i = 0; i < SIZE; i++) data_v[i] = DWIDTH'(i);
        applyStimulus();
        idleInputs();
        measureLatency("t1_latency");
        checkOutput("t1_lane0", out_lanes[0], 0);
        checkOutput("t1_lane17", out_lanes[17], 17);
        waitDrain("t1_drain");

        $display("[TB] single cross on switch 0 of stage 0");
        @(posedge clk);
        #1;
        setIdentity();
        perm_v[0] = 1;
        perm_v[1] = 0;
        ctrl_v[0] = 1'b1;
        applyStimulus();
        idleInputs();
        measureLatency("t2_latency");
        checkOutput("t2_lane0", out_lanes[0], 1);
        checkOutput("t2_lane1", out_lanes[1], 0);
        checkOutput("t2_lane2", out_lanes[2], 2);
        checkOutput("t2_lane31", out_lanes[31], 31);
        waitDrain("t2_drain");

        $display("[TB] golden permutation");
        @(posedge clk);
        #1;
        perm_v = gold_perm;
        ctrl_v = gold_ctrl;
        applyStimulus();
        idleInputs();
        measureLatency("t3_latency");
        checkOutput("t3_lane27", out_lanes[27], 0);
        checkOutput("t3_lane14", out_lanes[14], 31);
        checkOutput("t3_lane12", out_lanes[12], 16);
        waitDrain("t3_drain");

        $display("[TB] backpressure stream");
        @(posedge clk);
        #1;
        stall_seen = 1'b0;
        cnt0 = out_count;
        setIdentity();
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < SIZE; i++) data_v[i] = DWIDTH'(b);
                    applyStimulus();
                end
                idleInputs();
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitDrain("t4_drain");
        checkOutput("t4_in_ready_dropped", stall_seen, 1);
        checkOutput("t4_beats_out", out_count - cnt0, 8);

        $display("[TB] per-beat ctrl alternation");
        @(posedge clk);
        #1;
        cnt0 = out_count;
        for (int b = 0; b < 6; b++) begin
            if (b % 2 == 0) setIdentity();
            else begin
                perm_v = gold_perm;
                ctrl_v = gold_ctrl;
            end
            for (int i = 0; i < SIZE; i++) data_v[i] = DWIDTH'(b * 64 + i);
            applyStimulus();
        end
        idleInputs();
        waitDrain("t5_drain");
        checkOutput("t5_beats_out", out_count - cnt0, 6);

        $display("[TB] reset mid-stream");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        perm_v = gold_perm;
        ctrl_v = gold_ctrl;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < SIZE; i++) data_v[i] = DWIDTH'(100 + b);
            applyStimulus();
        end
        idleInputs();
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        checkOutput("t6_valid_before_reset", out_valid, 1);
        #2;
        n_rst = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("t6_reset_out_valid", out_valid, 0);
        checkOutput("t6_reset_out_data_zero", out_lanes == '0, 1);
        checkOutput("t6_reset_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t6_held_out_valid", out_valid, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        setIdentity();
        for (int i = 0; i < SIZE; i++) data_v[i] = DWIDTH'(200 + i);
        applyStimulus();
        idleInputs();
        measureLatency("t6_latency");
        checkOutput("t6_lane3", out_lanes[3], 203);
        waitDrain("t6_drain");
        repeat (10) @(negedge clk);
        checkOutput("t6_no_stale", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/benes_xbar_pipelined.md
Name: benes_xbar_pipelined

Overview:
- Pipelined Beneš data crossbar. It consumes the control word produced by the cabbage control generators and physically permutes SIZE data lanes. It is the receiving end of the perm -> ctrl interface.
- It sits between the lane producer, for example vector register read, and the lane consumer. Each beat carries its own ctrl word, so the permutation can change every cycle.
- Valid/ready handshake on both sides. Stage pipeline registers collapse bubbles.

Parameters:
- SIZE, 32, number of lanes; must be a power of 2 and >= 4.
- DWIDTH, 32, bits per lane.
- REG_STRIDE, 2, number of switch stages between pipeline registers.
- TAGWIDTH, $clog2(SIZE), derived.
- STAGES, 2*TAGWIDTH-1, derived; 9 for SIZE=32.
- BITWIDTH, STAGES*(SIZE/2), derived; 144 for SIZE=32.
- LAT, ceil(STAGES/REG_STRIDE), derived; 5 for the defaults.

Ports:
- clk, input, 1, clock.
- n_rst, input, 1, asynchronous active-low reset.
- in_valid, input, 1, input beat valid.
- in_ready, output, 1, crossbar accepts a beat.
- in_ctrl, input, BITWIDTH, switch settings. Format is identical to the cabbage ctrl output.
- in_data, input, SIZE x DWIDTH (unpacked [SIZE-1:0]), lane data.
- out_valid, output, 1, output beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, SIZE x DWIDTH, permuted lanes.

Behaviour:
- Ctrl bit mapping:
  - Bit s*(SIZE/2)+k drives switch k of stage s. Stage 0 is the input side.
  - Switch k joins positions 2k and 2k+1. 0 = straight, 1 = cross (the two positions swap).
- Inter-stage wiring, with M = SIZE>>s:
  - For s < TAGWIDTH-1, positions are taken in blocks of size M. Switch-output 2k goes to block position k, and 2k+1 goes to k+M/2 (unshuffle).
  - Stages s >= TAGWIDTH-1 mirror this with the inverse shuffle, using M = SIZE>>(STAGES-2-s).
  - The final stage output equals out_data lane order.
- End-to-end: when ctrl = cabbage(perm), out_data[perm[i]] = in_data[i].
- Pipeline structure:
  - LAT register slots. A slot is inserted after stage s when (s+1)%REG_STRIDE==0 or s==STAGES-1.
  - Each slot holds: valid, data, and the ctrl bits for the stages not yet applied. Ctrl bits for applied stages are dropped.
- Advance rules:
  - Slot j loads from slot j-1 when (slot j empty) or (slot j advances).
  - The last slot advances when out_valid && out_ready.
  - in_ready = slot0 empty || slot0 advances. It is combinational from out_ready through the chain; no registered skid.
  - A beat is accepted when in_valid && in_ready.
  - A valid slot that cannot advance holds its data and ctrl stable.
- Outputs:
  - out_valid = last slot valid. out_data = last slot data.
  - While out_valid && !out_ready, out_data is stable.
- Latency: with no stall, an input accepted at edge t appears on out_valid/out_data after edge t+LAT-1 (LAT register edges including the accepting edge).
- Throughput is 1 beat/cycle. Beats are never reordered, dropped or duplicated.
- Simultaneous events:
  - Accept and emit in the same cycle are allowed when full.
  - A bubble between beats is collapsed if downstream is stalled.
- Reset (n_rst=0, async):
  - All slot valids clear immediately; data and ctrl registers go to 0.
  - out_valid=0 and out_data=0.
  - in_ready evaluates to 1 during and after reset.
  - Beats in flight at mid-stream reset are discarded.
- X on in_ctrl/in_data while in_valid=0 must not propagate into any valid slot.

Decomposition:
- Shared package xbar_params (in xbar_params.svh) holds:
  - the TAGWIDTH/STAGES/BITWIDTH derivation functions;
  - a ctrl_bit_index(stage, switch) function;
  - a shuffle_dst(stage, pos) function, shared with the cabbage generators so both ends agree.
- Sub-module benes_stage: one combinational column of SIZE/2 2x2 switches plus its output shuffle, parameterised by stage index. The top level instantiates STAGES of them and the slot registers.

Test Plan:
1. Identity: ctrl=0, in_data[i]=i, one beat. out_data[i]=i; out_valid rises exactly LAT-1 cycles after the accept edge; in_ready stays 1.
2. Single cross: ctrl bit 0 = 1, all others 0, in_data[i]=i. out_data[0]=1, out_data[1]=0, all other lanes unchanged.
3. Golden permutation:
   - perm[31..0] = {14,22,25,11,21,6,15,5,30,23,18,28,19,17,31,12,26,16,13,3,9,8,0,1,10,20,7,4,29,2,24,27}, with ctrl from cabbage_singlecycle and in_data[i]=i.
   - Expect out_data[27]=0, out_data[14]=31, and in general out_data[perm[i]]=i for all i.
4. Backpressure:
   - Stream 8 back-to-back beats (identity ctrl, in_data lanes = beat number 0..7); hold out_ready=0 for cycles 3-6.
   - in_ready=0 once all LAT slots fill. Output beats 0..7 arrive in order with none lost, and out_data is stable while stalled.
5. Per-beat ctrl: alternate identity and the golden ctrl every cycle for 6 beats. Each output is permuted by its own ctrl.
6. Reset mid-stream: assert n_rst=0 while 3 beats are in flight. out_valid=0 and out_data=0 immediately. After release, the first new beat emerges after LAT-1 cycles and no stale beat appears.
